seq_muldiv: RTL and testbench

- Parametrised multi-cycle multiply/divide unit for the bus-based CPU datapath.
- Operand A comes from the Y register and operand B from the bus.
- Produces a 2*WIDTH result that the datapath loads into ZHigh/ZLow, then HI/LO.
- Replaces single-cycle combinational MUL/DIV with an iterative shift-add / restoring-divide engine, with a start/busy/done handshake the control unit waits on.

---
 rtl/seq_muldiv.sv | 156 +++++++++++++++
 tb/tb_seq_muldiv.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_muldiv.sv
// rtl/seq_muldiv.sv - iterative shift-add multiplier / restoring divider with start/busy/done handshake
module seq_muldiv #(
   parameter int WIDTH     = 32,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic                 div_zero,
   output logic [2*WIDTH-1:0]   result
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   state_t               state;
   logic [1:0]           op_q;
   logic [WIDTH-1:0]     a_q;
   logic [WIDTH-1:0]     b_q;
   logic [WIDTH-1:0]     m_q;      // multiplicand magnitude or divisor magnitude
   logic [2*WIDTH-1:0]   acc;      // MUL: {partial, multiplier}; DIV: {rem, quo}
   logic [CW-1:0]        cnt;
   logic                 sign_q;
   logic                 sign_r;

   logic                 is_div;
   logic                 is_signed;
   logic                 a_neg;
   logic                 b_neg;
   logic [WIDTH-1:0]     mag_a;
   logic [WIDTH-1:0]     mag_b;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_trial;
   logic [2*WIDTH-1:0]   mul_step;
   logic [2*WIDTH-1:0]   div_step;
   logic [WIDTH-1:0]     rem_fix;
   logic [WIDTH-1:0]     quo_fix;
   logic [2*WIDTH-1:0]   fix_val;

   // Operand decode, one iteration step of each engine, and the final sign fix-up
   always_comb begin
      is_div    = op_q[1];
      is_signed = SIGNED_EN && !op_q[0];
      a_neg     = is_signed && a_q[WIDTH-1];
      b_neg     = is_signed && b_q[WIDTH-1];
      mag_a     = a_neg ? -a_q : a_q;
      mag_b     = b_neg ? -b_q : b_q;

      // Shift-add: add multiplicand into the upper half when the current multiplier bit is set,
      // then shift the whole accumulator right keeping the carry.
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
      mul_step  = {mul_sum, acc[WIDTH-1:1]};

      // Restoring divide: the shifted remainder needs one extra bit, its MSB flags a borrow.
      div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, m_q};
      if (!div_trial[WIDTH]) begin
         div_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         div_step = {acc[2*WIDTH-2:0], 1'b0};
      end

      rem_fix = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      quo_fix = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      if (is_div) begin
         fix_val = {rem_fix, quo_fix};
      end else begin
         fix_val = sign_q ? -acc : acc;
      end
   end

   // Control FSM with registered handshake outputs and datapath registers
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         result   <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         m_q      <= '0;
         acc      <= '0;
         cnt      <= '0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  a_q      <= a;
                  b_q      <= b;
                  op_q     <= op;
                  div_zero <= 1'b0;
                  busy     <= 1'b1;
                  state    <= S_PREP;
               end else begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            S_PREP: begin
               sign_q <= a_neg ^ b_neg;
               sign_r <= a_neg;
               cnt    <= CW'(WIDTH - 1);
               if (is_div && (b_q == '0)) begin
                  div_zero <= 1'b1;
                  result   <= {a_q, {WIDTH{1'b1}}};
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= S_DONE;
               end else if (is_div) begin
                  acc   <= {{WIDTH{1'b0}}, mag_a};
                  m_q   <= mag_b;
                  state <= S_RUN;
               end else begin
                  acc   <= {{WIDTH{1'b0}}, mag_b};
                  m_q   <= mag_a;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               acc <= is_div ? div_step : mul_step;
               cnt <= cnt - CW'(1);
               if (cnt == '0) begin
                  state <= S_FIX;
               end
            end
            S_FIX: begin
               result <= fix_val;
               busy   <= 1'b0;
               done   <= 1'b1;
               state  <= S_DONE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_muldiv.sv
// tb/tb_seq_muldiv.sv - scoreboard bench for seq_muldiv at WIDTH=32 and WIDTH=8 (signed / unsigned-only)
module tb_seq_muldiv;

   localparam logic [1:0] OP_MUL  = 2'b00;
   localparam logic [1:0] OP_MULU = 2'b01;
   localparam logic [1:0] OP_DIV  = 2'b10;
   localparam logic [1:0] OP_DIVU = 2'b11;

   logic clk = 1'b0;
   logic clr = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   // 32-bit signed-capable instance
   logic        s32 = 1'b0;
   logic [1:0]  op32 = '0;
   logic [31:0] a32 = '0;
   logic [31:0] b32 = '0;
   logic        busy32, done32, dz32;
   logic [63:0] r32;

   // 8-bit instances sharing one stimulus: signed-enabled and unsigned-only
   logic        s8 = 1'b0;
   logic [1:0]  op8 = '0;
   logic [7:0]  a8 = '0;
   logic [7:0]  b8 = '0;
   logic        busy8s, done8s, dz8s;
   logic [15:0] r8s;
   logic        busy8u, done8u, dz8u;
   logic [15:0] r8u;

   seq_muldiv #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (
      .clk(clk), .clr(clr), .start(s32), .op(op32), .a(a32), .b(b32),
      .busy(busy32), .done(done32), .div_zero(dz32), .result(r32)
   );

   seq_muldiv #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8s (
      .clk(clk), .clr(clr), .start(s8), .op(op8), .a(a8), .b(b8),
      .busy(busy8s), .done(done8s), .div_zero(dz8s), .result(r8s)
   );

   seq_muldiv #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8u (
      .clk(clk), .clr(clr), .start(s8), .op(op8), .a(a8), .b(b8),
      .busy(busy8u), .done(done8u), .div_zero(dz8u), .result(r8u)
   );

   // expected entries are {div_zero, result}
   logic [64:0] q32[$];
   logic [16:0] q8s[$];
   logic [16:0] q8u[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // monitors: pop and compare whenever a done pulse is presented
   logic        prev32 = 1'b0;
   logic [64:0] e32;
   always @(negedge clk) begin
      if (done32) begin
         chk("done32_one_cycle", 64'(prev32), 64'd0);
         if (q32.size() == 0) begin
            chk("done32_unexpected", 64'(done32), 64'd0);
         end else begin
            e32 = q32.pop_front();
            chk("result32", r32, e32[63:0]);
            chk("div_zero32", 64'(dz32), 64'(e32[64]));
         end
      end
      prev32 = done32;
   end

   logic [16:0] e8s;
   always @(negedge clk) begin
      if (done8s) begin
         if (q8s.size() == 0) begin
            chk("done8s_unexpected", 64'(done8s), 64'd0);
         end else begin
            e8s = q8s.pop_front();
            chk("result8s", 64'(r8s), 64'(e8s[15:0]));
            chk("div_zero8s", 64'(dz8s), 64'(e8s[16]));
         end
      end
   end

   logic [16:0] e8u;
   always @(negedge clk) begin
      if (done8u) begin
         if (q8u.size() == 0) begin
            chk("done8u_unexpected", 64'(done8u), 64'd0);
         end else begin
            e8u = q8u.pop_front();
            chk("result8u", 64'(r8u), 64'(e8u[15:0]));
            chk("div_zero8u", 64'(dz8u), 64'(e8u[16]));
         end
      end
   end

   task automatic issue32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [64:0] exp);
      @(negedge clk);
      op32 = o; a32 = x; b32 = y; s32 = 1'b1;
      q32.push_back(exp);
      @(posedge clk);
      #1;
      s32 = 1'b0; a32 = ~x; b32 = ~y; op32 = ~o;
   endtask

   task automatic wait_done32();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done32) break;
      end
      if (!done32) chk("timeout32", 64'(done32), 64'd1);
   endtask

   task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [64:0] exp);
      issue32(o, x, y, exp);
      wait_done32();
   endtask

   task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic [16:0] exps, input logic [16:0] expu);
      @(negedge clk);
      op8 = o; a8 = x; b8 = y; s8 = 1'b1;
      q8s.push_back(exps);
      q8u.push_back(expu);
      @(posedge clk);
      #1;
      s8 = 1'b0; a8 = ~x; b8 = ~y;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done8s) break;
      end
      if (!done8s) chk("timeout8", 64'(done8s), 64'd1);
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      chk("rst_busy32", 64'(busy32), 64'd0);
      chk("rst_done32", 64'(done32), 64'd0);
      chk("rst_dz32", 64'(dz32), 64'd0);
      chk("rst_result32", r32, 64'd0);
      chk("rst_result8s", 64'(r8s), 64'd0);
      chk("rst_result8u", 64'(r8u), 64'd0);
      clr = 1'b1;

      // timed signed MUL: busy through FIX, done exactly at edge WIDTH+2
      issue32(OP_MUL, 32'd7, 32'hFFFF_FFFD, {1'b0, 64'hFFFF_FFFF_FFFF_FFEB});
      chk("busy_edge0", 64'(busy32), 64'd1);
      for (int e = 1; e <= 34; e++) begin
         @(posedge clk);
         #1;
         chk($sformatf("busy_edge%0d", e), 64'(busy32), (e <= 33) ? 64'd1 : 64'd0);
         chk($sformatf("done_edge%0d", e), 64'(done32), (e == 34) ? 64'd1 : 64'd0);
      end

      run32(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 64'hFFFF_FFFE_0000_0001});
      run32(OP_DIV,  32'hFFFF_FFF9, 32'd2,         {1'b0, 64'hFFFF_FFFF_FFFF_FFFD});
      run32(OP_DIVU, 32'd100,       32'd7,         {1'b0, 64'h0000_0002_0000_000E});
      run32(OP_DIV,  32'd7,         32'hFFFF_FFFE, {1'b0, 64'h0000_0001_FFFF_FFFD});
      run32(OP_MUL,  32'hFFFF_FFFB, 32'hFFFF_FFFA, {1'b0, 64'd30});

      // divide by zero: done after edge 1, then back-to-back start in the DONE cycle clears div_zero
      issue32(OP_DIV, 32'd5, 32'd0, {1'b1, 64'h0000_0005_FFFF_FFFF});
      @(posedge clk);
      #1;
      chk("dz_done_edge1", 64'(done32), 64'd1);
      chk("dz_flag_edge1", 64'(dz32), 64'd1);
      op32 = OP_MULU; a32 = 32'd3; b32 = 32'd5; s32 = 1'b1;
      q32.push_back({1'b0, 64'd15});
      @(posedge clk);
      #1;
      s32 = 1'b0;
      chk("b2b_busy", 64'(busy32), 64'd1);
      chk("b2b_dz_cleared", 64'(dz32), 64'd0);
      wait_done32();

      run32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 64'h0000_0000_8000_0000});

      // start pulse during RUN is ignored and result holds the previous value meanwhile
      issue32(OP_DIVU, 32'd1000, 32'd10, {1'b0, 64'd100});
      repeat (5) @(posedge clk);
      #1;
      op32 = OP_MULU; a32 = 32'd9; b32 = 32'd9; s32 = 1'b1;
      @(posedge clk);
      #1;
      s32 = 1'b0;
      chk("ignored_start_busy", 64'(busy32), 64'd1);
      chk("hold_result", r32, 64'h0000_0000_8000_0000);
      wait_done32();

      // asynchronous reset mid-RUN
      issue32(OP_MUL, 32'd12345, 32'd678, {1'b0, 64'd8369910});
      repeat (10) @(posedge clk);
      #2;
      clr = 1'b0;
      #1;
      chk("abort_busy", 64'(busy32), 64'd0);
      chk("abort_done", 64'(done32), 64'd0);
      chk("abort_dz", 64'(dz32), 64'd0);
      chk("abort_result", r32, 64'd0);
      q32.delete();
      repeat (2) @(negedge clk);
      clr = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_abort_idle", 64'(busy32), 64'd0);
      run32(OP_MUL, 32'hFFFF_FFFB, 32'd6, {1'b0, 64'hFFFF_FFFF_FFFF_FFE2});

      // WIDTH=8: signed-enabled vs unsigned-only instance
      run8(OP_MUL,  8'd7,   8'hFD,  {1'b0, 16'hFFEB}, {1'b0, 16'h06EB});
      run8(OP_MULU, 8'hFF,  8'hFF,  {1'b0, 16'hFE01}, {1'b0, 16'hFE01});
      run8(OP_DIV,  8'hF9,  8'd2,   {1'b0, 16'hFFFD}, {1'b0, 16'h017C});
      run8(OP_DIVU, 8'd100, 8'd7,   {1'b0, 16'h020E}, {1'b0, 16'h020E});
      run8(OP_DIV,  8'd5,   8'd0,   {1'b1, 16'h05FF}, {1'b1, 16'h05FF});
      run8(OP_DIV,  8'h80,  8'hFF,  {1'b0, 16'h0080}, {1'b0, 16'h8000});
      run8(OP_MUL,  8'h80,  8'h7F,  {1'b0, 16'hC080}, {1'b0, 16'h3F80});

      repeat (3) @(negedge clk);
      chk("queue32_drained", 64'(q32.size()), 64'd0);
      chk("queue8s_drained", 64'(q8s.size()), 64'd0);
      chk("queue8u_drained", 64'(q8u.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
